// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//    Program-counter / instruction-fetch sequencer feeding the decode/ALU stage.
//    Walks the program counter sequentially, resolves absolute jumps and
//    conditional relative branches through a small target LUT, and runs a
//    start / halt handshake while counting retired instructions.
//
// Ports
//    clk_i          system clock, all state updates on the rising edge
//    rst_ni         asynchronous active-low reset
//    start_i        begin execution (honoured only while idle)
//    start_addr_i   first PC loaded on start
//    halt_i         decoded halt instruction at the current PC
//    branch_abs_i   unconditional jump, target = LUT[target_idx_i]
//    branch_en_i    conditional relative branch, taken when cond_flag_i = 1
//    cond_flag_i    ALU comparison result for the current instruction
//    target_idx_i   LUT index used by jump / branch
//    stall_i        freeze PC, state and counter this cycle
//    lut_we_i       LUT write enable
//    lut_widx_i     LUT write index
//    lut_wdata_i    LUT write data (absolute address or two's-complement offset)
//    prog_ctr_o     current instruction address
//    running_o      high while executing
//    done_o         one-cycle pulse after the halt instruction retires
//    inst_count_o   retired instructions since last start, saturating
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int PC_W  = 10,
   parameter int LUT_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [PC_W-1:0]  start_addr_i,
   input  logic             halt_i,
   input  logic             branch_abs_i,
   input  logic             branch_en_i,
   input  logic             cond_flag_i,
   input  logic [LUT_W-1:0] target_idx_i,
   input  logic             stall_i,
   input  logic             lut_we_i,
   input  logic [LUT_W-1:0] lut_widx_i,
   input  logic [PC_W-1:0]  lut_wdata_i,
   output logic [PC_W-1:0]  prog_ctr_o,
   output logic             running_o,
   output logic             done_o,
   output logic [CNT_W-1:0] inst_count_o
);

   localparam int LUT_N = 1 << LUT_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  lut_q [LUT_N];
   logic [PC_W-1:0]  lut_rd;

   // An instruction retires on every unstalled cycle spent in RUN.
   logic             retire;

   // Combinational read from the registered array: a same-cycle write to the
   // same index is only visible from the following cycle onward.
   assign lut_rd = lut_q[target_idx_i];
   assign retire = (state_q == S_RUN) && !stall_i;

   // ---------------------------------------------------------------------------
   // Target LUT (reset to zero, so no block RAM inference is possible)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < LUT_N; i++) begin
            lut_q[i] <= '0;
         end
      end else if (lut_we_i) begin
         lut_q[lut_widx_i] <= lut_wdata_i;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN:   if (retire && halt_i) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs, decoded from the registered state
   // ---------------------------------------------------------------------------
   always_comb begin
      running_o = (state_q == S_RUN);
      done_o    = (state_q == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // Datapath: program counter and retired-instruction counter
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      if (state_q == S_IDLE && start_i) begin
         pc_d  = start_addr_i;
         cnt_d = '0;
      end else if (retire) begin
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         // Halt leaves the PC on the halt instruction.
         if (halt_i) begin
            pc_d = pc_q;
         end else if (branch_abs_i) begin
            pc_d = lut_rd;
         end else if (branch_en_i && cond_flag_i) begin
            // Modular add of a two's-complement offset handles backward branches.
            pc_d = pc_q + lut_rd;
         end else begin
            pc_d = pc_q + PC_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q  <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   assign prog_ctr_o   = pc_q;
   assign inst_count_o = cnt_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Program-counter / instruction-fetch sequencer. Sits directly upstream of the ALU/decode stage.
- Supplies ProgCtr to instruction memory.
- Consumes the ALU's comparison result (EQ/NEQ/GEQ ops) as CondFlag to resolve branches.
- Branch targets come from an internal 16-entry target LUT, written through a config port.
- Runs a start/halt handshake with the testbench top and counts retired instructions.

Parameters:
- PC_W, 10, width of the program counter and of LUT entries
- LUT_W, 4, index width of the target LUT (2**LUT_W entries)
- CNT_W, 16, width of the retired-instruction counter

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin execution; honoured only in IDLE
- StartAddr  in  PC_W  first PC loaded on Start
- Halt  in  1  decoded halt instruction at current PC
- BranchAbs  in  1  unconditional jump; target = LUT[TargetIdx]
- BranchEn  in  1  conditional relative branch; taken when CondFlag=1
- CondFlag  in  1  ALU comparison result bit for current instruction
- TargetIdx  in  LUT_W  LUT index for jump/branch
- StallIn  in  1  freeze PC, state and counter this cycle
- LutWe  in  1  LUT write enable
- LutWIdx  in  LUT_W  LUT write index
- LutWData  in  PC_W  LUT write data (absolute address or two's-complement offset)
- ProgCtr  out  PC_W  current instruction address
- Running  out  1  high in RUN
- Done  out  1  one-cycle pulse after halt retires
- InstCount  out  CNT_W  retired instructions since last Start, saturating

Behaviour:
- Reset (async, Reset=0):
  - ProgCtr=0, state=IDLE, Running=0, Done=0, InstCount=0.
  - All LUT entries=0.
  - Reset mid-RUN aborts immediately; no Done pulse.
- States: IDLE, RUN, DONE. Outputs are registered and decoded from state: Running=(state==RUN), Done=(state==DONE).
- IDLE:
  - Start=1 -> ProgCtr<=StartAddr, InstCount<=0, state<=RUN.
  - Otherwise hold. Halt/branch/stall inputs are ignored.
- RUN, StallIn=1: ProgCtr, state and InstCount all hold. Stall has highest priority, above Halt.
- RUN, StallIn=0: InstCount<=sat(InstCount+1). Next-PC priority:
  1. Halt=1: ProgCtr holds, state<=DONE.
  2. BranchAbs=1: ProgCtr<=LUT[TargetIdx].
  3. BranchEn=1 and CondFlag=1: ProgCtr<=ProgCtr+LUT[TargetIdx], mod 2**PC_W. LUT value is treated as two's complement, so negative offsets wrap.
  4. Otherwise ProgCtr<=ProgCtr+1, wrapping from 2**PC_W-1 to 0.
  - BranchEn=1 with CondFlag=0 is sequential (+1).
- DONE: lasts exactly one cycle, then state<=IDLE. ProgCtr and InstCount hold until the next Start. Start during DONE is ignored.
- Start while in RUN or DONE is ignored; no restart.
- InstCount saturates at 2**CNT_W-1 and never wraps.
- LUT write:
  - Synchronous, allowed in any state.
  - Read is combinational from array contents. A same-cycle write to the index being read returns the OLD value for that cycle's branch.
- Latency:
  - Branch/jump target visible on ProgCtr one cycle after the branch instruction is presented.
  - Done rises one cycle after the Halt cycle.

Test Plan:
- Reset low mid-RUN at ProgCtr=0x05:
  - All outputs go to 0 without waiting for a clock edge.
  - LUT reads back 0.
  - No Done pulse.
- Start with StartAddr=0x010, run 4 cycles without branches, then Halt:
  - ProgCtr sequence 0x010,0x011,0x012,0x013,0x014, holding 0x014.
  - Done pulses exactly one cycle later.
  - InstCount=5.
  - Running drops with Done.
- LUT[3]=0x3FE (-2), ProgCtr=0x001, BranchEn=1, CondFlag=1, TargetIdx=3:
  - Next ProgCtr=0x3FF (wrap).
  - Repeat with CondFlag=0 -> ProgCtr=0x002.
- LUT[5]=0x100. Same cycle: BranchAbs=1, BranchEn=1, CondFlag=1, TargetIdx=5 -> ProgCtr=0x100 (absolute wins).
  - Halt together with BranchAbs -> PC holds, DONE entered.
- StallIn=1 for 3 cycles with Halt=1 asserted:
  - ProgCtr, InstCount and Running unchanged.
  - Halt takes effect only on the first unstalled cycle.
- LutWe=1 to index 2 (0x050) in the same cycle as BranchAbs with TargetIdx=2, old LUT[2]=0x020 -> ProgCtr=0x020.
  - A later jump via index 2 -> 0x050.
  - Start pulsed during RUN has no effect.
